hazard_forward_unit: RTL and testbench

- Parametrised successor to the EX-stage forwarding unit. Resolves RAW hazards for NPORTS EX-stage source operands from the MEM and WB stages.
- Adds load-use hazard detection at ID with a multi-cycle stall FSM (configurable load latency), a global freeze for a busy data memory, ID flush handling, and a saturating stall-cycle counter.
- Sits beside the ID/EX/MEM/WB pipeline registers. Its outputs drive the operand muxes, the PC/IF-ID write enables and the ID/EX bubble insertion.

---
 rtl/hazard_forward_unit_pkg.sv | 25 ++
 rtl/hazard_forward_unit_fwd_port_sel.sv | 41 ++++
 rtl/hazard_forward_unit.sv | 149 ++++++++++++++
 tb/tb_hazard_forward_unit.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_forward_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_forward_unit_pkg
//  Description : Shared encodings for the forwarding / load-use hazard unit:
//                operand-mux selects, stall FSM states, register zero.
//  Revision    : 1.0 - initial release
// ============================================================================
package hazard_forward_unit_pkg;

   // Operand mux selects driven onto fwd_sel, one 2-bit field per port
   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   // Load-use stall FSM: RUN covers the first stall cycle, WAIT the rest
   typedef enum logic [0:0] {
      ST_RUN  = 1'b0,
      ST_WAIT = 1'b1
   } hzState_t;

   // Register zero is hard-wired; writes to it never produce a hazard
   localparam int REG_ZERO = 0;

endpackage : hazard_forward_unit_pkg
`default_nettype wire

// File: rtl/hazard_forward_unit_fwd_port_sel.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_forward_unit_fwd_port_sel
//  Description : Forwarding compare for one EX source operand. The MEM stage
//                holds the younger result, so it wins over WB; register zero
//                is never forwarded.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_forward_unit_fwd_port_sel
   import hazard_forward_unit_pkg::*;
#(
   parameter int AW = 5
) (
   input  logic [AW-1:0] exSrc,
   input  logic [AW-1:0] memRd,
   input  logic          memRegWrite,
   input  logic [AW-1:0] wbRd,
   input  logic          wbRegWrite,
   output logic [1:0]    fwdSel
);

   localparam logic [AW-1:0] C_REG_ZERO = AW'(REG_ZERO);

   logic w_memHit;
   logic w_wbHit;

   assign w_memHit = memRegWrite && (memRd != C_REG_ZERO) && (memRd == exSrc);
   assign w_wbHit  = wbRegWrite  && (wbRd  != C_REG_ZERO) && (wbRd  == exSrc);

   // Priority select: MEM first, then WB, else register file
   always_comb begin
      fwdSel = FWD_RF;
      if (w_memHit) begin
         fwdSel = FWD_MEM;
      end else if (w_wbHit) begin
         fwdSel = FWD_WB;
      end
   end

endmodule : hazard_forward_unit_fwd_port_sel
`default_nettype wire

// File: rtl/hazard_forward_unit.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_forward_unit
//  Description : EX-stage operand forwarding for NPORTS sources, ID-stage
//                load-use detection with a LOAD_LAT-cycle stall FSM, global
//                freeze on a busy data memory, ID flush handling and a
//                saturating stall-cycle statistics counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_forward_unit
   import hazard_forward_unit_pkg::*;
#(
   parameter int AW       = 5,
   parameter int NPORTS   = 2,
   parameter int LOAD_LAT = 1,
   parameter int CNT_W    = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NPORTS*AW-1:0] ex_src,
   input  logic [NPORTS*AW-1:0] id_src,
   input  logic [NPORTS-1:0]    id_src_use,
   input  logic [AW-1:0]        ex_rd,
   input  logic                 ex_mem_read,
   input  logic [AW-1:0]        mem_rd,
   input  logic                 mem_reg_write,
   input  logic [AW-1:0]        wb_rd,
   input  logic                 wb_reg_write,
   input  logic                 mem_busy,
   input  logic                 flush_id,
   input  logic                 stat_clr,
   output logic [2*NPORTS-1:0]  fwd_sel,
   output logic                 pc_write,
   output logic                 ifid_write,
   output logic                 idex_bubble,
   output logic                 freeze,
   output logic [CNT_W-1:0]     stall_cycles
);

   // Wait counter needs at least one bit even when LOAD_LAT == 1 never uses WAIT
   localparam int             CW         = (LOAD_LAT > 1) ? $clog2(LOAD_LAT) : 1;
   localparam logic [CW-1:0]  C_CNT_INIT = CW'((LOAD_LAT > 1) ? (LOAD_LAT - 2) : 0);
   localparam logic [AW-1:0]  C_REG_ZERO = AW'(REG_ZERO);

   hzState_t         r_state;
   logic [CW-1:0]    r_waitCnt;
   logic [CNT_W-1:0] r_stallCycles;

   logic w_srcMatch;
   logic w_hazard;
   logic w_stall;

   // ------------------------------------------------------------------------
   // Forwarding: one compare slice per EX source operand
   // ------------------------------------------------------------------------
   genvar gi;
   generate
      for (gi = 0; gi < NPORTS; gi++) begin : g_port
         hazard_forward_unit_fwd_port_sel #(
            .AW (AW)
         ) u_portSel (
            .exSrc       (ex_src[gi*AW +: AW]),
            .memRd       (mem_rd),
            .memRegWrite (mem_reg_write),
            .wbRd        (wb_rd),
            .wbRegWrite  (wb_reg_write),
            .fwdSel      (fwd_sel[2*gi +: 2])
         );
      end
   endgenerate

   // ------------------------------------------------------------------------
   // Load-use detection at ID
   // ------------------------------------------------------------------------

   // Any used ID source that names the load destination in EX
   always_comb begin
      w_srcMatch = 1'b0;
      for (int i = 0; i < NPORTS; i++) begin
         if (id_src_use[i] && (id_src[i*AW +: AW] == ex_rd)) begin
            w_srcMatch = 1'b1;
         end
      end
   end

   assign w_hazard = ex_mem_read && (ex_rd != C_REG_ZERO) && w_srcMatch;

   // A squashed ID instruction cannot be waiting on the load, so flush wins
   assign w_stall  = !flush_id &&
                     (((r_state == ST_RUN) && w_hazard) || (r_state == ST_WAIT));

   // ------------------------------------------------------------------------
   // Pipeline control outputs; a busy memory overrides everything
   // ------------------------------------------------------------------------
   assign freeze      = mem_busy;
   assign pc_write    = !mem_busy && !w_stall;
   assign ifid_write  = !mem_busy && !w_stall;
   assign idex_bubble = !mem_busy && (w_stall || flush_id);

   // Stall FSM: RUN spends the first stall cycle, WAIT counts the remainder
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= ST_RUN;
         r_waitCnt <= '0;
      end else if (!mem_busy) begin
         if (flush_id) begin
            r_state   <= ST_RUN;
            r_waitCnt <= '0;
         end else begin
            case (r_state)
               ST_RUN: begin
                  if (w_hazard && (LOAD_LAT > 1)) begin
                     r_state   <= ST_WAIT;
                     r_waitCnt <= C_CNT_INIT;
                  end
               end
               ST_WAIT: begin
                  if (r_waitCnt == '0) begin
                     r_state <= ST_RUN;
                  end else begin
                     r_waitCnt <= r_waitCnt - CW'(1);
                  end
               end
               default: begin
                  r_state   <= ST_RUN;
                  r_waitCnt <= '0;
               end
            endcase
         end
      end
   end

   // Saturating count of load-use stall cycles; clear beats increment
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_stallCycles <= '0;
      end else if (!mem_busy) begin
         if (stat_clr) begin
            r_stallCycles <= '0;
         end else if (w_stall && (r_stallCycles != {CNT_W{1'b1}})) begin
            r_stallCycles <= r_stallCycles + CNT_W'(1);
         end
      end
   end

   assign stall_cycles = r_stallCycles;

endmodule : hazard_forward_unit
`default_nettype wire

// File: tb/tb_hazard_forward_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_forward_unit
//  Description : Directed self-checking bench. Three instances share one set
//                of inputs: A (LOAD_LAT=1), B (LOAD_LAT=3), C (LOAD_LAT=1,
//                CNT_W=2). Each scenario starts from a reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_forward_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic [9:0]  exSrc;
   logic [9:0]  idSrc;
   logic [1:0]  idSrcUse;
   logic [4:0]  exRd;
   logic        exMemRead;
   logic [4:0]  memRd;
   logic        memRegWrite;
   logic [4:0]  wbRd;
   logic        wbRegWrite;
   logic        memBusy;
   logic        flushId;
   logic        statClr;

   logic [3:0]  fwdSelA, fwdSelB, fwdSelC;
   logic        pcWriteA, pcWriteB, pcWriteC;
   logic        ifidWriteA, ifidWriteB, ifidWriteC;
   logic        idexBubbleA, idexBubbleB, idexBubbleC;
   logic        freezeA, freezeB, freezeC;
   logic [15:0] stallCyclesA, stallCyclesB;
   logic [1:0]  stallCyclesC;

   int numChecks = 0;
   int numErrors = 0;

   always #5 clk = ~clk;

   hazard_forward_unit #(.AW(5), .NPORTS(2), .LOAD_LAT(1), .CNT_W(16)) u_dutA (
      .clk(clk), .reset(reset), .ex_src(exSrc), .id_src(idSrc), .id_src_use(idSrcUse),
      .ex_rd(exRd), .ex_mem_read(exMemRead), .mem_rd(memRd), .mem_reg_write(memRegWrite),
      .wb_rd(wbRd), .wb_reg_write(wbRegWrite), .mem_busy(memBusy), .flush_id(flushId),
      .stat_clr(statClr), .fwd_sel(fwdSelA), .pc_write(pcWriteA), .ifid_write(ifidWriteA),
      .idex_bubble(idexBubbleA), .freeze(freezeA), .stall_cycles(stallCyclesA));

   hazard_forward_unit #(.AW(5), .NPORTS(2), .LOAD_LAT(3), .CNT_W(16)) u_dutB (
      .clk(clk), .reset(reset), .ex_src(exSrc), .id_src(idSrc), .id_src_use(idSrcUse),
      .ex_rd(exRd), .ex_mem_read(exMemRead), .mem_rd(memRd), .mem_reg_write(memRegWrite),
      .wb_rd(wbRd), .wb_reg_write(wbRegWrite), .mem_busy(memBusy), .flush_id(flushId),
      .stat_clr(statClr), .fwd_sel(fwdSelB), .pc_write(pcWriteB), .ifid_write(ifidWriteB),
      .idex_bubble(idexBubbleB), .freeze(freezeB), .stall_cycles(stallCyclesB));

   hazard_forward_unit #(.AW(5), .NPORTS(2), .LOAD_LAT(1), .CNT_W(2)) u_dutC (
      .clk(clk), .reset(reset), .ex_src(exSrc), .id_src(idSrc), .id_src_use(idSrcUse),
      .ex_rd(exRd), .ex_mem_read(exMemRead), .mem_rd(memRd), .mem_reg_write(memRegWrite),
      .wb_rd(wbRd), .wb_reg_write(wbRegWrite), .mem_busy(memBusy), .flush_id(flushId),
      .stat_clr(statClr), .fwd_sel(fwdSelC), .pc_write(pcWriteC), .ifid_write(ifidWriteC),
      .idex_bubble(idexBubbleC), .freeze(freezeC), .stall_cycles(stallCyclesC));

   // Single comparison point: counts every check, reports mismatches
   task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      numChecks++;
      if (got !== exp) begin
         numErrors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clearInputs();
      exSrc = '0; idSrc = '0; idSrcUse = '0; exRd = '0; exMemRead = 1'b0;
      memRd = '0; memRegWrite = 1'b0; wbRd = '0; wbRegWrite = 1'b0;
      memBusy = 1'b0; flushId = 1'b0; statClr = 1'b0;
   endtask

   task automatic doReset();
      clearInputs();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
   endtask

   // Load in EX writes r5, ID instruction reads r5 on port 1
   task automatic driveHazard();
      exMemRead = 1'b1;
      exRd      = 5'd5;
      idSrc     = {5'd5, 5'd9};
      idSrcUse  = 2'b10;
   endtask

   // Time limit so the bench always terminates
   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      clearInputs();
      reset = 1'b1;
      #2;
      // Reset state
      checkEq("rst_pcWriteA",     32'(pcWriteA), 32'd1);
      checkEq("rst_ifidWriteA",   32'(ifidWriteA), 32'd1);
      checkEq("rst_bubbleA",      32'(idexBubbleA), 32'd0);
      checkEq("rst_freezeA",      32'(freezeA), 32'd0);
      checkEq("rst_stallCyclesB", 32'(stallCyclesB), 32'd0);
      tick();
      reset = 1'b0;
      #1;

      // Forwarding priority and register-zero guard
      exSrc = {5'd7, 5'd3};
      memRd = 5'd3; memRegWrite = 1'b1;
      wbRd  = 5'd3; wbRegWrite  = 1'b1;
      #1 checkEq("fwd_memBeatsWb", 32'(fwdSelA), 32'b0010);
      wbRd = 5'd7;
      #1 checkEq("fwd_memAndWb",   32'(fwdSelA), 32'b0110);
      checkEq("fwd_memAndWbB",     32'(fwdSelB), 32'b0110);
      memRegWrite = 1'b0; wbRd = 5'd3;
      #1 checkEq("fwd_memNoWrite", 32'(fwdSelA), 32'b0001);
      memRd = 5'd7; memRegWrite = 1'b1; wbRd = 5'd7;
      #1 checkEq("fwd_port1Mem",   32'(fwdSelA), 32'b1000);
      memRd = 5'd0; wbRd = 5'd0;
      #1 checkEq("fwd_rdZero",     32'(fwdSelA), 32'b0000);
      exSrc = {5'd0, 5'd0};
      #1 checkEq("fwd_srcZero",    32'(fwdSelA), 32'b0000);

      // Load-use, LOAD_LAT = 1
      doReset();
      driveHazard();
      #1;
      checkEq("ll1_pcWrite",   32'(pcWriteA), 32'd0);
      checkEq("ll1_ifidWrite", 32'(ifidWriteA), 32'd0);
      checkEq("ll1_bubble",    32'(idexBubbleA), 32'd1);
      tick();
      exMemRead = 1'b0;
      #1;
      checkEq("ll1_release",   32'(pcWriteA), 32'd1);
      checkEq("ll1_noBubble",  32'(idexBubbleA), 32'd0);
      checkEq("ll1_count",     32'(stallCyclesA), 32'd1);
      driveHazard();
      idSrcUse = 2'b01;
      #1 checkEq("ll1_unused",  32'(pcWriteA), 32'd1);
      idSrc = {5'd0, 5'd0}; exRd = 5'd0; idSrcUse = 2'b11;
      #1 checkEq("ll1_rdZero",  32'(pcWriteA), 32'd1);
      tick();
      checkEq("ll1_countHold", 32'(stallCyclesA), 32'd1);

      // Load-use, LOAD_LAT = 3
      doReset();
      driveHazard();
      #1 checkEq("ll3_c1", 32'(pcWriteB), 32'd0);
      tick();
      exMemRead = 1'b0;
      #1;
      checkEq("ll3_c2",       32'(pcWriteB), 32'd0);
      checkEq("ll3_c2Bubble", 32'(idexBubbleB), 32'd1);
      tick();
      checkEq("ll3_c3",       32'(pcWriteB), 32'd0);
      tick();
      checkEq("ll3_done",     32'(pcWriteB), 32'd1);
      checkEq("ll3_doneBub",  32'(idexBubbleB), 32'd0);
      checkEq("ll3_count",    32'(stallCyclesB), 32'd3);

      // Freeze for two cycles in the middle of WAIT
      doReset();
      driveHazard();
      tick();
      exMemRead = 1'b0;
      memBusy   = 1'b1;
      #1;
      checkEq("frz_freeze1",  32'(freezeB), 32'd1);
      checkEq("frz_pcWrite1", 32'(pcWriteB), 32'd0);
      checkEq("frz_bubble1",  32'(idexBubbleB), 32'd0);
      tick();
      checkEq("frz_freeze2",  32'(freezeB), 32'd1);
      checkEq("frz_countHold", 32'(stallCyclesB), 32'd1);
      tick();
      memBusy = 1'b0;
      #1;
      checkEq("frz_unfrozen", 32'(freezeB), 32'd0);
      checkEq("frz_stallA",   32'(pcWriteB), 32'd0);
      checkEq("frz_stallBub", 32'(idexBubbleB), 32'd1);
      tick();
      checkEq("frz_stallB",   32'(pcWriteB), 32'd0);
      tick();
      checkEq("frz_done",     32'(pcWriteB), 32'd1);
      checkEq("frz_count",    32'(stallCyclesB), 32'd3);

      // Flush in the second WAIT cycle
      doReset();
      driveHazard();
      tick();
      exMemRead = 1'b0;
      #1 checkEq("fl_wait1", 32'(pcWriteB), 32'd0);
      tick();
      flushId = 1'b1;
      #1;
      checkEq("fl_pcWrite",  32'(pcWriteB), 32'd1);
      checkEq("fl_bubble",   32'(idexBubbleB), 32'd1);
      tick();
      flushId = 1'b0;
      #1;
      checkEq("fl_runPc",    32'(pcWriteB), 32'd1);
      checkEq("fl_runBub",   32'(idexBubbleB), 32'd0);
      checkEq("fl_count",    32'(stallCyclesB), 32'd2);

      // stat_clr together with a stall
      doReset();
      driveHazard();
      tick();
      checkEq("clr_before", 32'(stallCyclesA), 32'd1);
      statClr = 1'b1;
      tick();
      statClr   = 1'b0;
      exMemRead = 1'b0;
      #1 checkEq("clr_after", 32'(stallCyclesA), 32'd0);

      // Saturation with CNT_W = 2
      doReset();
      driveHazard();
      repeat (5) tick();
      exMemRead = 1'b0;
      #1;
      checkEq("sat_countC", 32'(stallCyclesC), 32'd3);
      checkEq("sat_countA", 32'(stallCyclesA), 32'd5);

      // Asynchronous reset in the middle of WAIT
      doReset();
      driveHazard();
      tick();
      exMemRead = 1'b0;
      #1;
      checkEq("ar_inWait",  32'(pcWriteB), 32'd0);
      checkEq("ar_preCnt",  32'(stallCyclesB), 32'd1);
      reset = 1'b1;
      #1;
      checkEq("ar_pcWrite", 32'(pcWriteB), 32'd1);
      checkEq("ar_bubble",  32'(idexBubbleB), 32'd0);
      checkEq("ar_count",   32'(stallCyclesB), 32'd0);
      reset = 1'b0;
      tick();
      checkEq("ar_run",     32'(pcWriteB), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", numChecks, numErrors);
      $finish;
   end

endmodule : tb_hazard_forward_unit
`default_nettype wire
